// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared decision encoding and input-stage FSM types for the game
package game_pkg;

  localparam int DEC_W = 2;

  typedef enum logic [DEC_W-1:0] {DEC_A, DEC_B, DEC_C, DEC_D} decision_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DEBOUNCE,
    ST_COMMIT,
    ST_WAIT_RELEASE
  } din_state_t;

  function automatic logic is_onehot4(input logic [3:0] v);
    return (v != 4'b0000) && ((v & (v - 4'd1)) == 4'b0000);
  endfunction

  // Non-one-hot inputs map to DEC_A; callers gate on is_onehot4 first.
  function automatic decision_t onehot4_to_dec(input logic [3:0] oh);
    case (oh)
      4'b0010: return DEC_B;
      4'b0100: return DEC_C;
      4'b1000: return DEC_D;
      default: return DEC_A;
    endcase
  endfunction

endpackage

// File: rtl/btn_sync.sv
// rtl/btn_sync.sv - two-flop synchronizer bank for asynchronous button inputs
module btn_sync #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/decision_input.sv
// rtl/decision_input.sv - debounces four player buttons into a one-shot 2-bit decision
module decision_input
  import game_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       btn,
  output logic [DEC_W-1:0] Decision,
  output logic             decision_valid,
  output logic             multi_err,
  output logic [7:0]       press_count,
  output logic             busy
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 1) begin : g_param_check
    $error("decision_input: DEBOUNCE_CYCLES must be >= 1");
  end

  logic [3:0]       sync_btn;
  din_state_t       state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [3:0]       sample, sample_n;
  decision_t        dec_q, dec_n;
  logic             valid_n, multi_n;
  logic [7:0]       pc_n;

  btn_sync #(.W(4)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (btn),
    .q     (sync_btn)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= ST_IDLE;
      cnt            <= '0;
      sample         <= '0;
      dec_q          <= DEC_A;
      decision_valid <= 1'b0;
      multi_err      <= 1'b0;
      press_count    <= '0;
    end else begin
      state          <= state_n;
      cnt            <= cnt_n;
      sample         <= sample_n;
      dec_q          <= dec_n;
      decision_valid <= valid_n;
      multi_err      <= multi_n;
      press_count    <= pc_n;
    end
  end

  // Strobes default low so they last exactly the COMMIT cycle.
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    sample_n = sample;
    dec_n    = dec_q;
    valid_n  = 1'b0;
    multi_n  = 1'b0;
    pc_n     = press_count;
    case (state)
      ST_IDLE: begin
        if (sync_btn != 4'b0000) begin
          sample_n = sync_btn;
          cnt_n    = '0;
          state_n  = ST_DEBOUNCE;
        end
      end
      ST_DEBOUNCE: begin
        if (sync_btn == 4'b0000) begin
          cnt_n   = '0;
          state_n = ST_IDLE;
        end else if (sync_btn != sample) begin
          sample_n = sync_btn;
          cnt_n    = '0;
        end else if (cnt == CNT_LAST) begin
          state_n = ST_COMMIT;
          if (is_onehot4(sample)) begin
            dec_n   = onehot4_to_dec(sample);
            valid_n = 1'b1;
            pc_n    = press_count + 8'd1;
          end else begin
            multi_n = 1'b1;
          end
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      ST_COMMIT: begin
        cnt_n   = '0;
        state_n = ST_WAIT_RELEASE;
      end
      ST_WAIT_RELEASE: begin
        if (sync_btn != 4'b0000) begin
          cnt_n = '0;
        end else if (cnt == CNT_LAST) begin
          cnt_n   = '0;
          state_n = ST_IDLE;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      default: begin
        cnt_n   = '0;
        state_n = ST_IDLE;
      end
    endcase
  end

  assign Decision = dec_q;
  assign busy     = (state != ST_IDLE);

endmodule
